// File: rtl/axi4l_master.sv
// Purpose : bridges single core-side read/write requests onto an AXI4-lite bus (master side).
// Latency : minimum 3 cycles from acceptance to rsp_valid; each slave stall cycle adds one.
// Backpressure: req_ready only while idle; one transaction in flight; a silent slave stalls the block.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/req_ready        - request handshake; req_we/req_addr/req_wdata/req_be are the payload
//   rsp_valid/rsp_rdata/rsp_err- one-cycle completion pulse with read data and error status
//   aw*/w*/b*/ar*/r*           - AXI4-lite master channels
module axi4l_master #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  // core request / response
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [SW-1:0] req_be,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  // AXI4-lite write channels
  output logic [AW-1:0] awaddr,
  output logic          awvalid,
  input  logic          awready,
  output logic [DW-1:0] wdata,
  output logic [SW-1:0] wstrb,
  output logic          wvalid,
  input  logic          wready,
  input  logic          bvalid,
  input  logic [1:0]    bresp,
  output logic          bready,
  // AXI4-lite read channels
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  input  logic          rvalid,
  input  logic [1:0]    rresp,
  input  logic [DW-1:0] rdata,
  output logic          rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t state;

  // A write phase is finished once its valid has already dropped or it is
  // handshaking this cycle; AW and W may complete in either order.
  logic aw_done;
  logic w_done;

  // Only resp[1] carries the error indication (SLVERR/DECERR).
  logic unused_resp_lsb;

  assign aw_done         = !awvalid || awready;
  assign w_done          = !wvalid || wready;
  assign unused_resp_lsb = ^{bresp[0], rresp[0]};

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Address/data registers hold until the next acceptance.
            awaddr <= req_addr;
            araddr <= req_addr;
            wdata  <= req_wdata;
            wstrb  <= req_be;
            if (req_we) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end

        WR: begin
          if (aw_done && w_done) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b1;
            state   <= WRESP;
          end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
          end
        end

        WRESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_err   <= bresp[1];
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_err   <= rresp[1];
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RSP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
